// File: rtl/fetch_pkg.sv
`default_nettype none
//============================================================================
// Module      : fetch_pkg
// Description : Shared defaults, BTB entry type and index/tag/counter helpers
//               for the fetch-stage PC predictor.
// Revision    : 1.0 - initial release
//============================================================================
package fetch_pkg;

    localparam int          c_DEFAULT_DBITS    = 32;
    localparam int          c_DEFAULT_INSTSIZE = 4;
    localparam logic [31:0] c_DEFAULT_STARTPC  = 32'h100;

    // Entry fields are sized for the widest supported PC/counter; unused
    // upper bits are written as zero and trimmed by synthesis.
    localparam int c_MAX_PCW  = 64;
    localparam int c_MAX_CNTW = 8;

    typedef logic [c_MAX_PCW-1:0]  pcw_t;
    typedef logic [c_MAX_CNTW-1:0] cntw_t;

    typedef struct packed {
        logic  valid;
        logic  is_jmp;
        pcw_t  tag;
        pcw_t  target;
        cntw_t cnt;
    } btb_entry_t;

    function automatic pcw_t btb_index(input pcw_t pc, input int idx_bits);
        return (pc >> 2) & ((pcw_t'(1) << idx_bits) - pcw_t'(1));
    endfunction

    function automatic pcw_t btb_tag(input pcw_t pc, input int idx_bits);
        return pc >> (idx_bits + 2);
    endfunction

    function automatic cntw_t cnt_sat_inc(input cntw_t cnt, input int bits);
        cntw_t max_val;
        max_val = (cntw_t'(1) << bits) - cntw_t'(1);
        return (cnt == max_val) ? cnt : cnt + cntw_t'(1);
    endfunction

    function automatic cntw_t cnt_sat_dec(input cntw_t cnt);
        return (cnt == '0) ? cnt : cnt - cntw_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_predictor_if.sv
`default_nettype none
//============================================================================
// Module      : fetch_predictor_if
// Description : Fetch PC / EX resolution bundle between core and predictor.
// Revision    : 1.0 - initial release
//============================================================================
interface fetch_predictor_if
    import fetch_pkg::*;
#(
    parameter int DBITS = c_DEFAULT_DBITS
);

    logic             stall;
    logic [DBITS-1:0] pc_fe;
    logic [DBITS-1:0] pcpred_fe;
    logic             ex_valid;
    logic [DBITS-1:0] ex_pc;
    logic             ex_is_br;
    logic             ex_is_jmp;
    logic             ex_taken;
    logic [DBITS-1:0] ex_target;
    logic [DBITS-1:0] ex_pcpred;
    logic             mispred;
    logic [DBITS-1:0] pcgood;

    modport master (
        output stall, ex_valid, ex_pc, ex_is_br, ex_is_jmp, ex_taken,
               ex_target, ex_pcpred,
        input  pc_fe, pcpred_fe, mispred, pcgood
    );

    modport slave (
        input  stall, ex_valid, ex_pc, ex_is_br, ex_is_jmp, ex_taken,
               ex_target, ex_pcpred,
        output pc_fe, pcpred_fe, mispred, pcgood
    );

endinterface
`default_nettype wire

// File: rtl/btb_array.sv
`default_nettype none
//============================================================================
// Module      : btb_array
// Description : Direct-mapped BTB storage, two combinational read ports and
//               one synchronous write port; reset clears every entry.
// Revision    : 1.0 - initial release
//============================================================================
module btb_array
    import fetch_pkg::*;
#(
    parameter int BTBENTRIES = 16
) (
    input  wire logic                          clk,
    input  wire logic                          reset_n,
    input  wire logic [$clog2(BTBENTRIES)-1:0] i_rd_fe_idx,
    output      btb_entry_t                    o_rd_fe,
    input  wire logic [$clog2(BTBENTRIES)-1:0] i_rd_ex_idx,
    output      btb_entry_t                    o_rd_ex,
    input  wire logic                          i_we,
    input  wire logic [$clog2(BTBENTRIES)-1:0] i_wr_idx,
    input  wire btb_entry_t                    i_wr_data
);

    btb_entry_t r_mem [BTBENTRIES];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < BTBENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    // Reads see pre-write contents during the update cycle.
    assign o_rd_fe = r_mem[i_rd_fe_idx];
    assign o_rd_ex = r_mem[i_rd_ex_idx];

endmodule
`default_nettype wire

// File: rtl/fetch_predictor.sv
`default_nettype none
//============================================================================
// Module      : fetch_predictor
// Description : Fetch PC register with BTB + saturating-counter next-PC
//               prediction and EX-stage redirect. BTB built only when
//               FETCH_BTB_EN is defined; otherwise predicts PC+INSTSIZE.
// Revision    : 1.0 - initial release
//============================================================================
module fetch_predictor
    import fetch_pkg::*;
#(
    parameter int               DBITS      = c_DEFAULT_DBITS,
    parameter int               INSTSIZE   = c_DEFAULT_INSTSIZE,
    parameter logic [DBITS-1:0] STARTPC    = DBITS'(c_DEFAULT_STARTPC),
    parameter int               BTBENTRIES = 16,
    parameter int               CNTBITS    = 2
) (
    input wire logic         clk,
    input wire logic         reset_n,
    fetch_predictor_if.slave bus
);

    localparam int               c_IDX = $clog2(BTBENTRIES);
    localparam logic [DBITS-1:0] c_INC = DBITS'(INSTSIZE);

    logic [DBITS-1:0] r_pc;
    logic [DBITS-1:0] w_pc_seq;
    logic [DBITS-1:0] w_pcpred;
    logic [DBITS-1:0] w_ex_seq;
    logic [DBITS-1:0] w_actual;
    logic             w_ex_taken;
    logic             w_mispred;

    assign w_pc_seq   = r_pc + c_INC;
    assign w_ex_seq   = bus.ex_pc + c_INC;
    assign w_ex_taken = (bus.ex_is_br & bus.ex_taken) | bus.ex_is_jmp;
    assign w_actual   = w_ex_taken ? bus.ex_target : w_ex_seq;
    assign w_mispred  = bus.ex_valid && (w_actual != bus.ex_pcpred);

`ifdef FETCH_BTB_EN
    logic [c_IDX-1:0] w_fe_idx;
    logic [c_IDX-1:0] w_ex_idx;
    pcw_t             w_fe_tag;
    pcw_t             w_ex_tag;
    btb_entry_t       w_fe_rd;
    btb_entry_t       w_ex_rd;
    btb_entry_t       w_wr_data;
    logic             w_fe_hit;
    logic             w_fe_taken;
    logic             w_ex_hit;
    logic             w_we;

    assign w_fe_idx = c_IDX'(btb_index(pcw_t'(r_pc), c_IDX));
    assign w_ex_idx = c_IDX'(btb_index(pcw_t'(bus.ex_pc), c_IDX));
    assign w_fe_tag = btb_tag(pcw_t'(r_pc), c_IDX);
    assign w_ex_tag = btb_tag(pcw_t'(bus.ex_pc), c_IDX);

    assign w_fe_hit   = w_fe_rd.valid && (w_fe_rd.tag == w_fe_tag);
    assign w_fe_taken = w_fe_rd.is_jmp ||
                        (((w_fe_rd.cnt >> (CNTBITS - 1)) & cntw_t'(1)) != '0);
    assign w_pcpred   = (w_fe_hit && w_fe_taken) ? DBITS'(w_fe_rd.target) : w_pc_seq;
    assign w_ex_hit   = w_ex_rd.valid && (w_ex_rd.tag == w_ex_tag);

    always_comb begin
        w_we      = 1'b0;
        w_wr_data = w_ex_rd;
        if (bus.ex_valid) begin
            if (bus.ex_is_br || bus.ex_is_jmp) begin
                if (w_ex_hit || w_ex_taken) begin
                    w_we             = 1'b1;
                    w_wr_data.valid  = 1'b1;
                    w_wr_data.is_jmp = bus.ex_is_jmp;
                    w_wr_data.tag    = w_ex_tag;
                    w_wr_data.target = pcw_t'(bus.ex_target);
                    if (w_ex_hit) begin
                        w_wr_data.cnt = w_ex_taken ? cnt_sat_inc(w_ex_rd.cnt, CNTBITS)
                                                   : cnt_sat_dec(w_ex_rd.cnt);
                    end else begin
                        w_wr_data.cnt = cntw_t'(1) << (CNTBITS - 1);
                    end
                end
            end else if (w_ex_hit) begin
                // A non-control instruction aliasing a live entry evicts it.
                w_we            = 1'b1;
                w_wr_data.valid = 1'b0;
            end
        end
    end

    btb_array #(
        .BTBENTRIES (BTBENTRIES)
    ) u_btb_array (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_rd_fe_idx (w_fe_idx),
        .o_rd_fe     (w_fe_rd),
        .i_rd_ex_idx (w_ex_idx),
        .o_rd_ex     (w_ex_rd),
        .i_we        (w_we),
        .i_wr_idx    (w_ex_idx),
        .i_wr_data   (w_wr_data)
    );
`else
    assign w_pcpred = w_pc_seq;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc <= STARTPC;
        end else if (w_mispred) begin
            r_pc <= w_actual;
        end else if (!bus.stall) begin
            r_pc <= w_pcpred;
        end
    end

    assign bus.pc_fe     = r_pc;
    assign bus.pcpred_fe = w_pcpred;
    assign bus.mispred   = w_mispred;
    assign bus.pcgood    = w_actual;

endmodule
`default_nettype wire

// File: tb/tb_fetch_predictor.sv
`default_nettype none
//============================================================================
// Module      : tb_fetch_predictor
// Description : Directed scoreboard bench for fetch_predictor; expectations
//               follow FETCH_BTB_EN when defined, else the PC+4 build.
// Revision    : 1.0 - initial release
//============================================================================
module tb_fetch_predictor;
    import fetch_pkg::*;

`ifdef FETCH_BTB_EN
    localparam bit c_BTB = 1'b1;
`else
    localparam bit c_BTB = 1'b0;
`endif

    localparam logic [3:0] c_M_PC   = 4'b1000;
    localparam logic [3:0] c_M_PRED = 4'b0100;
    localparam logic [3:0] c_M_MIS  = 4'b0010;
    localparam logic [3:0] c_M_GOOD = 4'b0001;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    fetch_predictor_if #(.DBITS(32)) bus ();

    fetch_predictor #(
        .DBITS      (32),
        .INSTSIZE   (4),
        .STARTPC    (32'h100),
        .BTBENTRIES (16),
        .CNTBITS    (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic push(input string name, input logic [31:0] v);
        sb_t e;
        e.name = name;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.name, obs, e.val);
            end
        end
    endtask

    // One clock: drive after the edge, check combinational/registered
    // outputs at the falling edge.
    task automatic cyc(input string tag, input logic rn, input logic st,
                       input logic v, input logic br, input logic jmp, input logic tk,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] pp,
                       input logic [3:0] m, input logic [31:0] e_pc, input logic [31:0] e_pred,
                       input logic e_mis, input logic [31:0] e_good);
        @(posedge clk);
        #1;
        reset_n       = rn;
        bus.stall     = st;
        bus.ex_valid  = v;
        bus.ex_is_br  = br;
        bus.ex_is_jmp = jmp;
        bus.ex_taken  = tk;
        bus.ex_pc     = pc;
        bus.ex_target = tgt;
        bus.ex_pcpred = pp;
        if (m[3]) push({tag, ".pc_fe"}, e_pc);
        if (m[2]) push({tag, ".pcpred_fe"}, e_pred);
        if (m[1]) push({tag, ".mispred"}, {31'b0, e_mis});
        if (m[0]) push({tag, ".pcgood"}, e_good);
        @(negedge clk);
        if (m[3]) chk(bus.pc_fe);
        if (m[2]) chk(bus.pcpred_fe);
        if (m[1]) chk({31'b0, bus.mispred});
        if (m[0]) chk(bus.pcgood);
    endtask

    task automatic fetch(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pred);
        cyc(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
            c_M_PC | c_M_PRED | c_M_MIS, e_pc, e_pred, 1'b0, 32'h0);
    endtask

    task automatic res(input string tag, input logic br, input logic jmp, input logic tk,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] pp,
                       input logic e_mis, input logic [31:0] e_good);
        cyc(tag, 1'b1, 1'b0, 1'b1, br, jmp, tk, pc, tgt, pp,
            c_M_MIS | c_M_GOOD, 32'h0, 32'h0, e_mis, e_good);
    endtask

    // Steer fetch to 'target' with a plain instruction at target-4 whose
    // travelling prediction is deliberately wrong.
    task automatic redirect(input string tag, input logic [31:0] target);
        res(tag, 1'b0, 1'b0, 1'b0, target - 32'd4, 32'h0, 32'h0, 1'b1, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.stall     = 1'b0;
        bus.ex_valid  = 1'b0;
        bus.ex_is_br  = 1'b0;
        bus.ex_is_jmp = 1'b0;
        bus.ex_taken  = 1'b0;
        bus.ex_pc     = 32'h0;
        bus.ex_target = 32'h0;
        bus.ex_pcpred = 32'h0;

        cyc("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
            c_M_PC | c_M_MIS, 32'h100, 32'h0, 1'b0, 32'h0);
        cyc("rst_rel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
            c_M_PC | c_M_PRED | c_M_MIS, 32'h100, 32'h104, 1'b0, 32'h0);
        fetch("run1", 32'h104, 32'h108);
        fetch("run2", 32'h108, 32'h10C);

        cyc("cold_br", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h104, 32'h200, 32'h108,
            4'b1111, 32'h10C, 32'h110, 1'b1, 32'h200);
        fetch("cold_nxt", 32'h200, 32'h204);
        redirect("rd_a", 32'h104);
        fetch("bt_pred", 32'h104, c_BTB ? 32'h200 : 32'h108);

        res("nt1", 1'b1, 1'b0, 1'b0, 32'h104, 32'h200, c_BTB ? 32'h200 : 32'h108, c_BTB, 32'h108);
        redirect("rd_b", 32'h104);
        fetch("nt1_pred", 32'h104, 32'h108);
        res("nt2", 1'b1, 1'b0, 1'b0, 32'h104, 32'h200, 32'h108, 1'b0, 32'h108);
        res("nt3", 1'b1, 1'b0, 1'b0, 32'h104, 32'h200, 32'h108, 1'b0, 32'h108);
        redirect("rd_c", 32'h104);
        fetch("sat_lo", 32'h104, 32'h108);

        for (int i = 0; i < 4; i++) begin
            res("tk", 1'b1, 1'b0, 1'b1, 32'h104, 32'h200, 32'h108, 1'b1, 32'h200);
        end
        res("nt4", 1'b1, 1'b0, 1'b0, 32'h104, 32'h200, c_BTB ? 32'h200 : 32'h108, c_BTB, 32'h108);
        redirect("rd_d", 32'h104);
        fetch("sat_hi", 32'h104, c_BTB ? 32'h200 : 32'h108);

        redirect("rd_e", 32'h120);
        cyc("jal_same", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h120, 32'h40, 32'h124,
            4'b1111, 32'h120, 32'h124, 1'b1, 32'h40);
        fetch("jal_nxt", 32'h40, 32'h44);
        redirect("rd_f", 32'h120);
        fetch("jal_pred", 32'h120, c_BTB ? 32'h40 : 32'h124);

        res("alias_add", 1'b0, 1'b0, 1'b0, 32'h144, 32'h0, 32'h148, 1'b0, 32'h148);
        redirect("rd_g", 32'h104);
        fetch("alias_kept", 32'h104, c_BTB ? 32'h200 : 32'h108);
        res("alias_clr", 1'b0, 1'b0, 1'b0, 32'h104, 32'h0, 32'h108, 1'b0, 32'h108);
        redirect("rd_h", 32'h104);
        fetch("alias_gone", 32'h104, 32'h108);

        cyc("stall_mis", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1FC, 32'h0, 32'h0,
            c_M_MIS | c_M_GOOD, 32'h0, 32'h0, 1'b1, 32'h200);
        cyc("stall_a", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
            c_M_PC, 32'h200, 32'h0, 1'b0, 32'h0);
        cyc("stall_b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
            c_M_PC, 32'h200, 32'h0, 1'b0, 32'h0);
        cyc("stall_rel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
            c_M_PC | c_M_PRED, 32'h200, 32'h204, 1'b0, 32'h0);
        fetch("stall_run", 32'h204, 32'h208);
        cyc("stall_upd", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1F0, 32'h300, 32'h1F4,
            c_M_MIS | c_M_GOOD, 32'h0, 32'h0, 1'b1, 32'h300);
        redirect("rd_i", 32'h1F0);
        fetch("stall_upd_pred", 32'h1F0, c_BTB ? 32'h300 : 32'h1F4);

        cyc("mrst_a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
            4'b0000, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc("mrst_b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
            c_M_PC | c_M_MIS, 32'h100, 32'h0, 1'b0, 32'h0);
        cyc("mrst_rel", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1EC, 32'h0, 32'h0,
            c_M_PC | c_M_MIS | c_M_GOOD, 32'h100, 32'h0, 1'b1, 32'h1F0);
        fetch("mrst_clr", 32'h1F0, 32'h1F4);

        redirect("rd_wrap", 32'hFFFF_FFFC);
        fetch("wrap", 32'hFFFF_FFFC, 32'h0);

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
